mem_arbiter: RTL

- Shares the single external memory port between instruction fetch (IF) and the data access in the MEM stage.
- Arbitrates requests and keeps one transaction outstanding at a time.
- Drives the bus request/response handshake, returns read data to the winning requester, and raises a per-requester stall to the pipeline control.
- MEM has priority because it is the older instruction. A starvation guard guarantees forward progress for IF.

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one external memory port between instruction fetch and
// the MEM-stage data access. One transaction in flight; MEM wins arbitration
// unless IF has been passed over STARVE_MAX times in a row.
module mem_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    // instruction fetch port
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    output logic [DATA_W-1:0]     if_rdata,
    output logic                  if_valid,
    // data access port
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wmask,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_valid,
    // external bus
    output logic                  bus_req,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wmask,
    input  logic                  bus_ready,
    input  logic                  bus_rvalid,
    input  logic [DATA_W-1:0]     bus_rdata,
    // pipeline control
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int unsigned CNT_W = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] StarveLimit = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StDone} stateT;

    stateT            state, stateNext;
    logic             winnerMem;
    logic             grantMem, grantIf;
    logic [CNT_W-1:0] starveCnt, starveCntNext;

    // Arbitration: only in IDLE; MEM wins unless IF has hit the starvation limit.
    always_comb begin
        grantMem = 1'b0;
        grantIf  = 1'b0;
        if (state == StIdle) begin
            if (mem_req && !(if_req && starveCnt == StarveLimit)) begin
                grantMem = 1'b1;
            end else if (if_req) begin
                grantIf = 1'b1;
            end
        end
    end

    // Next-state logic for the single-outstanding-transaction sequencer.
    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle: if (grantMem || grantIf) stateNext = StReq;
            StReq:  if (bus_ready) stateNext = bus_we ? StDone : StWait;
            StWait: if (bus_rvalid) stateNext = StDone;
            StDone: stateNext = StIdle;
        endcase
    end

    // Starvation count: MEM grants that passed over a waiting IF, saturating.
    always_comb begin
        starveCntNext = starveCnt;
        if (grantIf) begin
            starveCntNext = '0;
        end else if (grantMem) begin
            if (!if_req) begin
                starveCntNext = '0;
            end else if (starveCnt != StarveLimit) begin
                starveCntNext = starveCnt + CNT_W'(1);
            end
        end
    end

    // State and starvation counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            starveCnt <= '0;
        end else begin
            state     <= stateNext;
            starveCnt <= starveCntNext;
        end
    end

    // Latch the winner and its request fields at grant; held until the next grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            winnerMem <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_wmask <= '0;
        end else if (grantMem) begin
            winnerMem <= 1'b1;
            bus_we    <= mem_we;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
            bus_wmask <= mem_wmask;
        end else if (grantIf) begin
            // fetches are always reads
            winnerMem <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
            bus_wmask <= '0;
        end
    end

    // Capture read response only in WAIT; responses in any other state are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            if_rdata  <= '0;
            mem_rdata <= '0;
        end else if (state == StWait && bus_rvalid) begin
            if (winnerMem) begin
                mem_rdata <= bus_rdata;
            end else begin
                if_rdata <= bus_rdata;
            end
        end
    end

    assign bus_req   = (state == StReq);
    assign if_valid  = (state == StDone) && !winnerMem;
    assign mem_valid = (state == StDone) && winnerMem;
    assign stall_if  = if_req & ~if_valid;
    assign stall_mem = mem_req & ~mem_valid;

endmodule
